// File: rtl/add_share_arb.sv
// add_share_arb: round-robin arbiter sharing one WIDTH-bit adder between four requesters.
// Each granted operand pair is summed and returned through a one-entry result register
// with a valid/ready response port, tagged with the requester index.
// Optional build macro ADD_SHARE_SAT_EN: saturate rsp_sum to all-ones on carry-out.
module add_share_arb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         req_ready,
  output logic               rsp_valid,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic               rsp_co,
  input  logic               rsp_ready
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_co_q;

  logic             slot_free;
  logic             found;
  logic [1:0]       gnt;
  logic [1:0]       idx;
  logic             accept;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum_res;

  // A new result can be taken when the register is empty or is being drained this cycle.
  assign slot_free = (state_q == StEmpty) | rsp_ready;

  // Rotating priority search starting at ptr_q, wrapping 3 -> 0.
  always_comb begin
    gnt   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req_valid[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end

  // One-hot ready to the winner; forced low while reset is asserted.
  always_comb begin
    req_ready = 4'b0000;
    if (rst_n && found && slot_free) begin
      req_ready = 4'b0001 << gnt;
    end
  end

  assign accept = |req_ready;

  // Operand mux feeding the single shared adder.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt == 2'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_ext = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef ADD_SHARE_SAT_EN
  assign sum_res = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
`else
  assign sum_res = sum_ext[WIDTH-1:0];
`endif

  // Next-state: accept fills (or refills) the register, a bare drain empties it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) state_d = StFull;
      end
      StFull: begin
        if (accept)         state_d = StFull;
        else if (rsp_ready) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
    if (accept) ptr_d = gnt + 2'd1;
  end

  // State and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Result register loads only on accept so a held or drained result stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q  <= 2'd0;
      rsp_sum_q <= '0;
      rsp_co_q  <= 1'b0;
    end else if (accept) begin
      rsp_id_q  <= gnt;
      rsp_sum_q <= sum_res;
      rsp_co_q  <= sum_ext[WIDTH];
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_co    = rsp_co_q;

endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb (WIDTH=4): table vectors, a result scoreboard,
// and hand-written sequences for reset, round-robin, backpressure and pointer hold.
// Honours ADD_SHARE_SAT_EN for the expected overflow sums.
module tb_add_share_arb;

  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_a;
  logic [4*W-1:0] req_b;
  logic [3:0]     req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_co;
  logic           rsp_ready;

  add_share_arb #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         co;
  } vec_t;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         co;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] id, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] s;
    s     = {1'b0, a} + {1'b0, b};
    e.id  = id;
    e.co  = s[W];
    e.sum = s[W-1:0];
`ifdef ADD_SHARE_SAT_EN
    if (s[W]) e.sum = '1;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
  endtask

  // Scoreboard: every response handshake pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got id %0d sum %0h want no response", rsp_id, rsp_sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_id", 32'(rsp_id), 32'(e.id));
        chk("sb_sum", 32'(rsp_sum), 32'(e.sum));
        chk("sb_co", 32'(rsp_co), 32'(e.co));
      end
    end
  end

  initial begin
    logic [W-1:0] ovf;
    exp_t         e;
`ifdef ADD_SHARE_SAT_EN
    ovf = 4'hF;
`else
    ovf = 4'h0;
`endif
    // id, a, b, expected sum, expected carry
    vecs[0] = '{2'd2, 4'd3,  4'd5,  4'd8,  1'b0};
    vecs[1] = '{2'd0, 4'd15, 4'd1,  ovf,   1'b1};
    vecs[2] = '{2'd1, 4'd7,  4'd8,  4'd15, 1'b0};
    vecs[3] = '{2'd3, 4'd9,  4'd9,  (ovf == 4'hF) ? 4'hF : 4'd2,  1'b1};
    vecs[4] = '{2'd2, 4'd0,  4'd0,  4'd0,  1'b0};
    vecs[5] = '{2'd0, 4'd15, 4'd15, (ovf == 4'hF) ? 4'hF : 4'd14, 1'b1};

    // Reset with all requesters valid: nothing granted, outputs zero.
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = 16'h1234;
    req_b     = 16'h5678;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'h0);
    chk("rst_rsp_co", 32'(rsp_co), 32'h0);
    tick();
    req_valid = 4'h0;
    rst_n     = 1'b1;

    // Table vectors: single requester, result in the following cycle.
    for (int i = 0; i < 6; i++) begin
      tick();
      req_valid = 4'b0001 << vecs[i].id;
      set_ops(int'(vecs[i].id), vecs[i].a, vecs[i].b);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("tbl_req_ready", 32'(req_ready), 32'(4'b0001 << vecs[i].id));
      #1 sb.push_back('{vecs[i].id, vecs[i].sum, vecs[i].co});
      tick();
      req_valid = 4'h0;
      @(negedge clk);
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'h1);
    end
    tick();

    // Reset while a result is held: rsp_valid drops at once, no response.
    req_valid = 4'b0010;
    set_ops(1, 4'd1, 4'd1);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("mid_req_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'hF;
    @(negedge clk);
    chk("mid_full", 32'(rsp_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    req_valid = 4'h0;
    rst_n     = 1'b1;

    // Round-robin: all four continuously valid, grants 0,1,2,3,0.
    tick();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 4'(i * 3 + 2), 4'(i + 5));
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_gnt", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      e = model(2'(k % 4), 4'((k % 4) * 3 + 2), 4'((k % 4) + 5));
      #1 sb.push_back(e);
      tick();
    end
    req_valid = 4'h0;
    @(negedge clk);
    chk("rr_last_valid", 32'(rsp_valid), 32'h1);
    tick();

    // Backpressure: result held with rsp_ready low, then drain and accept together.
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    set_ops(3, 4'd6, 4'd7);
    @(negedge clk);
    chk("bp_first", 32'(req_ready), 32'b1000);
    #1 sb.push_back(model(2'd3, 4'd6, 4'd7));
    tick();
    req_valid = 4'b0010;
    set_ops(1, 4'd2, 4'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(req_ready), 32'h0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_id", 32'(rsp_id), 32'd3);
      chk("bp_hold_sum", 32'(rsp_sum), 32'd13);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", 32'(req_ready), 32'b0010);
    #1 sb.push_back(model(2'd1, 4'd2, 4'd2));
    tick();
    req_valid = 4'h0;
    @(negedge clk);
    chk("bp_next_valid", 32'(rsp_valid), 32'h1);

    // Pointer hold: after the grant to 1, idle, then 0 and 3 together -> 3 then 0.
    for (int c = 0; c < 5; c++) tick();
    chk("idle_empty", 32'(rsp_valid), 32'h0);
    set_ops(0, 4'd10, 4'd3);
    set_ops(3, 4'd12, 4'd12);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("ptr_first", 32'(req_ready), 32'b1000);
    #1 sb.push_back(model(2'd3, 4'd12, 4'd12));
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("ptr_second", 32'(req_ready), 32'b0001);
    #1 sb.push_back(model(2'd0, 4'd10, 4'd3));
    tick();
    req_valid = 4'h0;
    tick();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_share_arb.md
# add_share_arb

Round-robin arbiter and sequencer that shares one WIDTH-bit adder between four requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes `{co, s} = a + b` on the shared adder, and returns a registered result tagged with the requester index over a valid/ready response port. It sits between the client blocks and the single adder instance, so the adder is never duplicated.

## Interface
- `WIDTH`, default 4: operand and sum width in bits; legal range is 1 to 32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  4  bit i high means requester i presents operands.
- `req_a`  in  4*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  4*WIDTH  operand b; same packing as `req_a`.
- `req_ready`  out  4  one-hot or zero; bit i high means requester i's operands are taken this cycle.
- `rsp_valid`  out  1  result register holds an unconsumed result.
- `rsp_id`  out  2  index of the requester that owns the result.
- `rsp_sum`  out  WIDTH  sum bits.
- `rsp_co`  out  1  carry-out, meaning unsigned overflow.
- `rsp_ready`  in  1  downstream accepts the result this cycle.
- One clock. Reset is asynchronous and active-low.

## Operation
- States:
  - EMPTY: result register free.
  - FULL: result held.
- `slot_free = (state==EMPTY) | rsp_ready`.
- Grant selection:
  - Search `req_valid` starting at pointer `ptr` (2 bits), upward with wrap 3→0.
  - The first set bit is `gnt`.
  - `req_ready[gnt] = slot_free & |req_valid`; all other bits are 0.
- Accept: a transfer happens when `req_valid[i] & req_ready[i]`. On the next edge:
  - `rsp_sum`/`rsp_co` ← `{1'b0,a_i} + {1'b0,b_i}`, computed WIDTH+1 bits wide.
  - `rsp_id` ← i.
  - state ← FULL.
  - `ptr` ← i+1 mod 4.
- Drain only: `rsp_valid & rsp_ready` with no accept → state ← EMPTY. Result fields hold their last values.
- Simultaneous drain and accept:
  - The new result overwrites the register and the state stays FULL.
  - This gives a sustained throughput of one sum per cycle.
- No accept: `ptr` is unchanged.
- FULL without `rsp_ready`:
  - All `req_ready` are 0.
  - Result fields are stable.
- Fairness: a requester holding `req_valid` is granted within 4 accepts.
- Requester rules:
  - Once `req_valid[i]` rises, it holds, with stable operands, until its handshake.
  - `req_valid` does not depend on `req_ready`.
- Responder rule: `rsp_ready` may toggle freely.

## Timing
- `req_ready` is combinational from state, `ptr`, `req_valid` and `rsp_ready`. There is no combinational path from operands to outputs.
- Latency: handshake in cycle N, `rsp_valid` high in cycle N+1.
- Reset values, applied immediately while `rst_n`=0:
  - state = EMPTY, `ptr` = 0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_co`=0.
  - `req_ready`=0, because `req_valid` is ignored while `rst_n` is low.
- Reset mid-operation: a held result is discarded with no response. The first grant after release uses `ptr`=0.
- Carry at boundaries: WIDTH-bit wrap, e.g. WIDTH=4, 15+1 gives `rsp_sum`=0, `rsp_co`=1.

## Configuration
- Macro: `ADD_SHARE_SAT_EN`.
- Defined: when the carry is 1, `rsp_sum` is forced to all-ones; `rsp_co` still reports 1. Example: 15+1 gives `rsp_sum`=15, `rsp_co`=1.
- Undefined: `rsp_sum` is the modular sum.
- Handshake, latency and arbitration are identical in both builds.

## Test plan
- Reset/idle: hold `rst_n`=0 with all `req_valid`=1 → `req_ready`=0 and all rsp outputs 0. Assert `rst_n` mid-FULL → `rsp_valid` drops the same cycle.
- Single request: requester 2 with a=3, b=5, `rsp_ready`=1 → `req_ready`=4'b0100 in cycle N; cycle N+1 gives `rsp_valid`=1, id=2, sum=8, co=0.
- Round-robin: all 4 valid continuously, `rsp_ready`=1 → grants 0,1,2,3,0 on consecutive cycles, one result per cycle, ids matching.
- Backpressure: result pending with `rsp_ready`=0 for 3 cycles → `req_ready`=0 and result stable. Raise `rsp_ready` → drain and next accept happen in the same cycle.
- Overflow, WIDTH=4: a=15, b=1 → sum=0, co=1 without the macro; sum=15, co=1 with `ADD_SHARE_SAT_EN`.
- Pointer hold: after a grant to 1, idle 5 cycles, then requests 0 and 3 arrive together → requester 3 is granted first, then 0.
